// File: rtl/tile_stats_accum.sv
// tile_stats_accum: per-tile mean/min/max over a tile-ordered pixel stream.
// Results are tagged with tile coordinates. The upstream done strobe is
// checked against the expected frame length, and a short frame sets a sticky
// error flag.
module tile_stats_accum #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int IMG_WIDTH   = 640,
  parameter  int IMG_HEIGHT  = 480,
  parameter  int TILE_WIDTH  = 16,
  parameter  int TILE_HEIGHT = 16,
  localparam int NTX         = IMG_WIDTH / TILE_WIDTH,
  localparam int NTY         = IMG_HEIGHT / TILE_HEIGHT,
  localparam int XW          = $clog2(NTX),
  localparam int YW          = $clog2(NTY)
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iDone_sig,
  output logic                  oValid,
  output logic [DATA_WIDTH-1:0] oMean,
  output logic [DATA_WIDTH-1:0] oMin,
  output logic [DATA_WIDTH-1:0] oMax,
  output logic [XW-1:0]         oTileX,
  output logic [YW-1:0]         oTileY,
  output logic                  oFrameDone,
  output logic                  oErr
);

  localparam int TPIX = TILE_WIDTH * TILE_HEIGHT;
  localparam int PW   = $clog2(TPIX);
  localparam int SW   = DATA_WIDTH + PW;

  localparam logic [PW-1:0] PIX_LAST = PW'(TPIX - 1);
  localparam logic [XW-1:0] TX_LAST  = XW'(NTX - 1);
  localparam logic [YW-1:0] TY_LAST  = YW'(NTY - 1);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                  state;
  logic [SW-1:0]           sum;
  logic [DATA_WIDTH-1:0]   mn;
  logic [DATA_WIDTH-1:0]   mx;
  logic [PW-1:0]           pix_cnt;
  logic [XW-1:0]           tx;
  logic [YW-1:0]           ty;

  logic [SW-1:0]           sum_next;
  logic [DATA_WIDTH-1:0]   min_next;
  logic [DATA_WIDTH-1:0]   max_next;
  logic                    tile_last;
  logic                    frame_last;
  logic                    abort;
  logic                    accept;

  // Next-pixel statistics and control decodes.
  // IDLE keeps stats at their cleared values, so the first pixel of a frame
  // goes through the same update path as any other pixel.
  always_comb begin
    sum_next   = sum + SW'(iData);
    min_next   = (iData < mn) ? iData : mn;
    max_next   = (iData > mx) ? iData : mx;
    tile_last  = (pix_cnt == PIX_LAST);
    frame_last = tile_last && (tx == TX_LAST) && (ty == TY_LAST);
    abort      = (state == ACCUM) && iDone_sig && !(iValid && frame_last);
    accept     = iValid && !abort;
  end

  // FSM, accumulators, tile/frame counters and registered result outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= IDLE;
      sum        <= '0;
      mn         <= '1;
      mx         <= '0;
      pix_cnt    <= '0;
      tx         <= '0;
      ty         <= '0;
      oValid     <= 1'b0;
      oMean      <= '0;
      oMin       <= '0;
      oMax       <= '0;
      oTileX     <= '0;
      oTileY     <= '0;
      oFrameDone <= 1'b0;
      oErr       <= 1'b0;
    end else begin
      oValid     <= 1'b0;
      oFrameDone <= 1'b0;
      if (abort) begin
        // Short frame: drop the partial tile and any coincident pixel.
        oErr    <= 1'b1;
        sum     <= '0;
        mn      <= '1;
        mx      <= '0;
        pix_cnt <= '0;
        tx      <= '0;
        ty      <= '0;
        state   <= IDLE;
      end else if (accept) begin
        state <= ACCUM;
        if (tile_last) begin
          oValid  <= 1'b1;
          oMean   <= sum_next[SW-1 -: DATA_WIDTH];
          oMin    <= min_next;
          oMax    <= max_next;
          oTileX  <= tx;
          oTileY  <= ty;
          sum     <= '0;
          mn      <= '1;
          mx      <= '0;
          pix_cnt <= '0;
          if (frame_last) begin
            oFrameDone <= 1'b1;
            state      <= IDLE;
            tx         <= '0;
            ty         <= '0;
          end else if (tx == TX_LAST) begin
            tx <= '0;
            ty <= ty + YW'(1);
          end else begin
            tx <= tx + XW'(1);
          end
        end else begin
          sum     <= sum_next;
          mn      <= min_next;
          mx      <= max_next;
          pix_cnt <= pix_cnt + PW'(1);
        end
      end
    end
  end

endmodule
